weight_bram_fetch_seq: RTL

//  Sequences one 16-bit weight BRAM (negedge-clocked, EN/WE, registered DO) for a neuron dot-product.
//  - On START, reads addresses 0..DEPTH-1 in order and streams each word out on a valid/ready port.
//  - In IDLE, grants a host write port access to the same BRAM so weights can be reloaded.
//  - Sits between the weight BRAM and the layer MAC datapath; one instance per BRAM.

---
 rtl/weight_bram_fetch_seq_if.sv | 55 +++++
 rtl/weight_bram_fetch_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_fetch_seq_if.sv
// Bus bundle for weight_bram_fetch_seq.
//
// Purpose: groups the control handshake, host write port, BRAM port and
// weight stream of one sequencer instance.
//   master : the sequencer side (drives BRAM port, stream, status, write ack)
//   slave  : the surroundings (host, BRAM, downstream MAC)
// Signals:
//   start/busy/done              sequence control
//   wr_req/wr_addr/wr_data/wr_ack host write port (IDLE only)
//   bram_addr/bram_di/bram_en/bram_we/bram_do  BRAM port
//   w_data/w_idx/w_valid/w_ready/w_last        weight stream
// Optional macro WSEQ_REPEAT_EN adds repeat_cnt (passes minus one).
interface weight_bram_fetch_seq_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_do;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_idx;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
`ifdef WSEQ_REPEAT_EN
  logic [7:0]        repeat_cnt;
`endif

  modport master (
`ifdef WSEQ_REPEAT_EN
    input  repeat_cnt,
`endif
    input  start, wr_req, wr_addr, wr_data, bram_do, w_ready,
    output busy, done, wr_ack, bram_addr, bram_di, bram_en, bram_we,
    output w_data, w_idx, w_valid, w_last
  );

  modport slave (
`ifdef WSEQ_REPEAT_EN
    output repeat_cnt,
`endif
    output start, wr_req, wr_addr, wr_data, bram_do, w_ready,
    input  busy, done, wr_ack, bram_addr, bram_di, bram_en, bram_we,
    input  w_data, w_idx, w_valid, w_last
  );
endinterface

// File: rtl/weight_bram_fetch_seq.sv
// weight_bram_fetch_seq
//
// Purpose: sequences one weight BRAM (negedge-clocked, EN/WE, registered DO)
// for a neuron dot-product. On start it reads addresses 0..DEPTH-1 in order
// and streams each word through a 2-entry output FIFO onto a valid/ready
// port. While idle it lets a host write port reload weights.
// Ports:
//   clk  : single clock; this controller acts on posedge, BRAM on negedge
//   rst  : synchronous active-high reset
//   bus  : weight_bram_fetch_seq_if.master (control, host write, BRAM, stream)
// Optional macro WSEQ_REPEAT_EN: repeat_cnt sampled at start selects
// repeat_cnt+1 back-to-back passes with a single done at the end.
module weight_bram_fetch_seq #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  weight_bram_fetch_seq_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE_ST} state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              wr_ack_reg;
  logic [ADDR_W-1:0] bram_addr_reg;
  logic [DATA_W-1:0] bram_di_reg;
  logic              bram_en_reg;
  logic              bram_we_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              rd_pend_reg;   // read issued last edge, DO lands this edge
  logic [1:0]        occ_reg;       // FIFO occupancy 0..2
  logic [DATA_W-1:0] data0_reg, data1_reg;
  logic [ADDR_W-1:0] idx0_reg, idx1_reg;
  logic              last0_reg, last1_reg;
`ifdef WSEQ_REPEAT_EN
  logic [7:0]        pass_left_reg;
`endif

  logic              pop;
  logic              push;
  logic [2:0]        avail;
  logic              can_issue;
  logic              cap_last;

  assign pop   = (occ_reg != 2'd0) && bus.w_ready;
  assign push  = rd_pend_reg;
  // Slots committed: buffered words plus the read in flight. A word leaving
  // this same edge frees its slot for the read issued now.
  assign avail     = {1'b0, occ_reg} + {2'b00, rd_pend_reg};
  assign can_issue = avail < (3'd2 + {2'b00, pop});
  // bram_addr_reg still holds the address of the read whose data lands now.
  assign cap_last  = (bram_addr_reg == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wr_ack_reg    <= 1'b0;
      bram_addr_reg <= '0;
      bram_di_reg   <= '0;
      bram_en_reg   <= 1'b0;
      bram_we_reg   <= 1'b0;
      rd_addr_reg   <= '0;
      rd_pend_reg   <= 1'b0;
      occ_reg       <= 2'd0;
      data0_reg     <= '0;
      data1_reg     <= '0;
      idx0_reg      <= '0;
      idx1_reg      <= '0;
      last0_reg     <= 1'b0;
      last1_reg     <= 1'b0;
`ifdef WSEQ_REPEAT_EN
      pass_left_reg <= 8'd0;
`endif
    end else begin
      bram_en_reg <= 1'b0;
      bram_we_reg <= 1'b0;
      wr_ack_reg  <= 1'b0;
      done_reg    <= 1'b0;
      rd_pend_reg <= 1'b0;

      // Output FIFO: entry 0 is the head presented on the stream port.
      case (occ_reg)
        2'd0: begin
          if (push) begin
            data0_reg <= bus.bram_do;
            idx0_reg  <= bram_addr_reg;
            last0_reg <= cap_last;
          end
        end
        2'd1: begin
          if (push && pop) begin
            data0_reg <= bus.bram_do;
            idx0_reg  <= bram_addr_reg;
            last0_reg <= cap_last;
          end else if (push) begin
            data1_reg <= bus.bram_do;
            idx1_reg  <= bram_addr_reg;
            last1_reg <= cap_last;
          end
        end
        default: begin
          if (pop) begin
            data0_reg <= data1_reg;
            idx0_reg  <= idx1_reg;
            last0_reg <= last1_reg;
            if (push) begin
              data1_reg <= bus.bram_do;
              idx1_reg  <= bram_addr_reg;
              last1_reg <= cap_last;
            end
          end
        end
      endcase
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg   <= FETCH;
            busy_reg    <= 1'b1;
            rd_addr_reg <= '0;
`ifdef WSEQ_REPEAT_EN
            pass_left_reg <= bus.repeat_cnt;
`endif
          end else if (bus.wr_req && !wr_ack_reg) begin
            // The host holds wr_req until it sees the ack, so the cycle
            // carrying the ack must not issue a second write.
            bram_en_reg   <= 1'b1;
            bram_we_reg   <= 1'b1;
            bram_addr_reg <= bus.wr_addr;
            bram_di_reg   <= bus.wr_data;
            wr_ack_reg    <= 1'b1;
          end
        end
        FETCH: begin
          if (can_issue) begin
            bram_en_reg   <= 1'b1;
            bram_addr_reg <= rd_addr_reg;
            rd_pend_reg   <= 1'b1;
            if (rd_addr_reg == LAST_ADDR) begin
`ifdef WSEQ_REPEAT_EN
              if (pass_left_reg != 8'd0) begin
                pass_left_reg <= pass_left_reg - 8'd1;
                rd_addr_reg   <= '0;
              end else begin
                state_reg <= DRAIN;
              end
`else
              state_reg <= DRAIN;
`endif
            end else begin
              rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Only the final pass's last word can still be buffered here.
          if (pop && last0_reg) begin
            state_reg <= DONE_ST;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.wr_ack    = wr_ack_reg;
  assign bus.bram_addr = bram_addr_reg;
  assign bus.bram_di   = bram_di_reg;
  assign bus.bram_en   = bram_en_reg;
  assign bus.bram_we   = bram_we_reg;
  assign bus.w_data    = data0_reg;
  assign bus.w_idx     = idx0_reg;
  assign bus.w_valid   = (occ_reg != 2'd0);
  assign bus.w_last    = last0_reg;

endmodule
